// File: rtl/pc_redirect_ctrl_if.sv
// rtl/pc_redirect_ctrl_if.sv - fetch/decode/redirect signal bundle for the PC redirect controller
interface pc_redirect_ctrl_if;
  // Fetch side
  logic        fetch_ack;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        flush_if;

  // Decode side
  logic        d_valid;
  logic        d_stall;
  logic [31:0] pc_d;
  logic        br_taken_d;
  logic        j_imi_d;
  logic        j_rs_d;
  logic [31:0] j_target_d;
  logic [31:0] br_target_d;
  logic        stall_d;

  // Exception / ERET redirects
  logic        exc_valid;
  logic [31:0] exc_target;
  logic        eret_valid;
  logic [31:0] epc;

  // Driver of fetch acks, decode state and redirect requests
  modport master (
    output fetch_ack, d_valid, d_stall, pc_d, br_taken_d, j_imi_d, j_rs_d,
           j_target_d, br_target_d, exc_valid, exc_target, eret_valid, epc,
    input  fetch_req, fetch_pc, flush_if, stall_d
  );

  // The controller itself
  modport slave (
    input  fetch_ack, d_valid, d_stall, pc_d, br_taken_d, j_imi_d, j_rs_d,
           j_target_d, br_target_d, exc_valid, exc_target, eret_valid, epc,
    output fetch_req, fetch_pc, flush_if, stall_d
  );
endinterface

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - next-fetch-PC sequencer with delay-slot aware branch redirect
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
  input  logic                 clk,
  input  logic                 resetn,
  pc_redirect_ctrl_if.slave    bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_DS = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] fetchPc;
  logic [31:0] pendingTarget;
  logic        fetchReq;
  logic        flushIf;

  logic        anyJump;
  logic        branchEvent;
  logic        redirect;
  logic [31:0] selTarget;
  logic [31:0] redirectTarget;
  logic [31:0] dsPc;
  logic [31:0] seqPc;
  logic        dsNotYetFetched;

  // Decode-side branch decision and address arithmetic (all 32-bit, carry dropped)
  always_comb begin
    anyJump         = bus.j_imi_d | bus.j_rs_d;
    branchEvent     = bus.d_valid & ~bus.d_stall & (bus.br_taken_d | anyJump);
    selTarget       = anyJump ? bus.j_target_d : bus.br_target_d;
    redirect        = bus.exc_valid | bus.eret_valid;
    redirectTarget  = bus.exc_valid ? bus.exc_target : bus.epc;
    dsPc            = bus.pc_d + 32'd4;
    seqPc           = fetchPc + 32'd4;
    // If fetch_pc still points at the delay slot, the slot has not been accepted yet
    dsNotYetFetched = (fetchPc == dsPc);
  end

  // Redirect FSM: owns fetch PC, pending branch target, flush pulse and fetch request
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= IDLE;
      fetchPc       <= RESET_PC;
      pendingTarget <= 32'd0;
      flushIf       <= 1'b0;
      fetchReq      <= 1'b0;
    end else begin
      fetchReq <= 1'b1;
      flushIf  <= 1'b0;
      if (redirect) begin
        // Exception/ERET wins in any state; an in-flight fetch is wrong-path
        fetchPc       <= redirectTarget;
        state         <= IDLE;
        pendingTarget <= 32'd0;
        flushIf       <= bus.fetch_ack;
      end else begin
        case (state)
          IDLE: begin
            if (branchEvent) begin
              if (dsNotYetFetched) begin
                if (bus.fetch_ack) begin
                  // Delay slot goes out this cycle; next fetch is the target
                  fetchPc <= selTarget;
                end else begin
                  // Must still fetch the delay slot; remember where to go after it
                  pendingTarget <= selTarget;
                  state         <= WAIT_DS;
                end
              end else begin
                // Delay slot already fetched; anything accepted now is wrong-path
                fetchPc <= selTarget;
                flushIf <= bus.fetch_ack;
              end
            end else if (bus.fetch_ack) begin
              fetchPc <= seqPc;
            end
          end
          WAIT_DS: begin
            // Decode is held; branch inputs are ignored until the slot is accepted
            if (bus.fetch_ack) begin
              fetchPc <= pendingTarget;
              state   <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Outputs are straight from registers
  assign bus.fetch_req = fetchReq;
  assign bus.fetch_pc  = fetchPc;
  assign bus.flush_if  = flushIf;
  assign bus.stall_d   = (state == WAIT_DS);

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed scoreboard bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        req;
  } exp_t;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;
  exp_t sb[$];

  pc_redirect_ctrl_if bus ();

  pc_redirect_ctrl #(.RESET_PC(32'hBFC00000)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  task automatic clr();
    bus.fetch_ack   = 1'b0;
    bus.d_valid     = 1'b0;
    bus.d_stall     = 1'b0;
    bus.pc_d        = 32'd0;
    bus.br_taken_d  = 1'b0;
    bus.j_imi_d     = 1'b0;
    bus.j_rs_d      = 1'b0;
    bus.j_target_d  = 32'd0;
    bus.br_target_d = 32'd0;
    bus.exc_valid   = 1'b0;
    bus.exc_target  = 32'd0;
    bus.eret_valid  = 1'b0;
    bus.epc         = 32'd0;
  endtask

  // Push expectation for the inputs just driven, clock once, pop and compare
  task automatic step(input string tag, input logic [31:0] ePc, input logic eFlush,
                      input logic eStall, input logic eReq);
    exp_t e;
    e.tag = tag; e.pc = ePc; e.flush = eFlush; e.stall = eStall; e.req = eReq;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".pc"},    bus.fetch_pc,          e.pc);
      check({e.tag, ".flush"}, {31'd0, bus.flush_if}, {31'd0, e.flush});
      check({e.tag, ".stall"}, {31'd0, bus.stall_d},  {31'd0, e.stall});
      check({e.tag, ".req"},   {31'd0, bus.fetch_req},{31'd0, e.req});
    end
  endtask

  // Force fetch_pc to a value via an exception redirect without a flush
  task automatic setPc(input string tag, input logic [31:0] pc);
    clr();
    bus.exc_valid  = 1'b1;
    bus.exc_target = pc;
    step(tag, pc, 1'b0, 1'b0, 1'b1);
    clr();
  endtask

  task automatic branch(input logic [31:0] pcD, input logic [31:0] tgt, input logic ack);
    clr();
    bus.d_valid     = 1'b1;
    bus.pc_d        = pcD;
    bus.br_taken_d  = 1'b1;
    bus.br_target_d = tgt;
    bus.fetch_ack   = ack;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clr();
    resetn = 1'b0;

    // Reset, with noise on inputs that must be ignored
    bus.fetch_ack = 1'b1;
    bus.exc_valid = 1'b1;
    bus.exc_target = 32'h1234_5678;
    step("reset", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
    clr();

    // Sequential fetch from the reset vector
    resetn = 1'b1;
    bus.fetch_ack = 1'b1;
    step("seq1", 32'hBFC00004, 1'b0, 1'b0, 1'b1);
    step("seq2", 32'hBFC00008, 1'b0, 1'b0, 1'b1);
    step("seq3", 32'hBFC0000C, 1'b0, 1'b0, 1'b1);
    bus.fetch_ack = 1'b0;
    step("hold", 32'hBFC0000C, 1'b0, 1'b0, 1'b1);

    // Branch with delay slot not yet accepted -> WAIT_DS
    setPc("set1004", 32'h0000_1004);
    branch(32'h1000, 32'h2000, 1'b0);
    step("br_wait", 32'h0000_1004, 1'b0, 1'b1, 1'b1);
    bus.j_imi_d    = 1'b1;
    bus.j_target_d = 32'h5555_0000;
    step("wait_ignore", 32'h0000_1004, 1'b0, 1'b1, 1'b1);
    clr();
    bus.fetch_ack = 1'b1;
    step("wait_ack", 32'h0000_2000, 1'b0, 1'b0, 1'b1);
    clr();
    step("after_wait", 32'h0000_2000, 1'b0, 1'b0, 1'b1);

    // Register jump after delay slot accepted, ack -> flush; jump target beats branch target
    setPc("set1008", 32'h0000_1008);
    bus.d_valid     = 1'b1;
    bus.pc_d        = 32'h1000;
    bus.j_rs_d      = 1'b1;
    bus.j_target_d  = 32'h3000;
    bus.br_target_d = 32'h7777;
    bus.fetch_ack   = 1'b1;
    step("jr_flush", 32'h0000_3000, 1'b1, 1'b0, 1'b1);
    clr();
    step("flush_drop", 32'h0000_3000, 1'b0, 1'b0, 1'b1);

    // Delay slot accepted in the same cycle as the branch -> straight to target
    setPc("set4004", 32'h0000_4004);
    clr();
    bus.d_valid    = 1'b1;
    bus.pc_d       = 32'h4000;
    bus.j_imi_d    = 1'b1;
    bus.j_target_d = 32'h6000;
    bus.fetch_ack  = 1'b1;
    step("j_same", 32'h0000_6000, 1'b0, 1'b0, 1'b1);

    // d_stall and !d_valid suppress the branch event
    branch(32'h5FFC, 32'h9000, 1'b1);
    bus.d_stall = 1'b1;
    step("dstall", 32'h0000_6004, 1'b0, 1'b0, 1'b1);
    branch(32'h6000, 32'h9000, 1'b1);
    bus.d_valid = 1'b0;
    step("dinvalid", 32'h0000_6008, 1'b0, 1'b0, 1'b1);

    // Exception beats ERET while in WAIT_DS; pending target dropped
    setPc("set1004b", 32'h0000_1004);
    branch(32'h1000, 32'h2000, 1'b0);
    step("br_wait2", 32'h0000_1004, 1'b0, 1'b1, 1'b1);
    clr();
    bus.exc_valid  = 1'b1;
    bus.exc_target = 32'hBFC00380;
    bus.eret_valid = 1'b1;
    bus.epc        = 32'h0000_8888;
    step("exc_in_wait", 32'hBFC00380, 1'b0, 1'b0, 1'b1);
    clr();
    bus.fetch_ack = 1'b1;
    step("exc_seq", 32'hBFC00384, 1'b0, 1'b0, 1'b1);

    // ERET alone with a fetch accepted -> flush
    clr();
    bus.eret_valid = 1'b1;
    bus.epc        = 32'h0040_0000;
    bus.fetch_ack  = 1'b1;
    step("eret_flush", 32'h0040_0000, 1'b1, 1'b0, 1'b1);
    clr();
    step("eret_drop", 32'h0040_0000, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of WAIT_DS
    setPc("set1004c", 32'h0000_1004);
    branch(32'h1000, 32'h2000, 1'b0);
    step("br_wait3", 32'h0000_1004, 1'b0, 1'b1, 1'b1);
    resetn = 1'b0;
    bus.fetch_ack = 1'b1;
    step("reset_wait", 32'hBFC00000, 1'b0, 1'b0, 1'b0);
    clr();
    resetn = 1'b1;
    bus.fetch_ack = 1'b1;
    step("post_reset", 32'hBFC00004, 1'b0, 1'b0, 1'b1);

    // 32-bit wrap of fetch_pc and of the pc_d+4 compare
    setPc("setFFFC", 32'hFFFF_FFFC);
    bus.fetch_ack = 1'b1;
    step("wrap", 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    branch(32'hFFFF_FFFC, 32'h0000_A000, 1'b1);
    step("wrap_ds", 32'h0000_A000, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'hBFC00000, the fetch address loaded on reset.
REQ-002 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-003 resetn  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 fetch_ack  input  1  fetch unit accepts fetch_pc this cycle.
REQ-005 d_valid  input  1  decode stage holds a valid instruction.
REQ-006 d_stall  input  1  decode stage stalled by others; no branch event is taken while high.
REQ-007 pc_d  input  32  PC of the instruction in decode.
REQ-008 br_taken_d  input  1  conditional branch in decode resolved taken.
REQ-009 j_imi_d  input  1  immediate jump (J/JAL) in decode.
REQ-010 j_rs_d  input  1  register jump (JR/JALR) in decode.
REQ-011 j_target_d  input  32  jump target.
REQ-012 br_target_d  input  32  conditional branch target.
REQ-013 exc_valid  input  1  exception redirect request.
REQ-014 exc_target  input  32  exception vector.
REQ-015 eret_valid  input  1  ERET redirect request.
REQ-016 epc  input  32  ERET return address.
REQ-017 fetch_req  output  1  fetch_pc is valid for fetch.
REQ-018 fetch_pc  output  32  registered next fetch address.
REQ-019 flush_if  output  1  one-cycle pulse: discard the fetch accepted in the previous cycle.
REQ-020 stall_d  output  1  decode must hold while the controller waits for the delay slot.

Function
REQ-021 Branch event SHALL be d_valid & ~d_stall & (br_taken_d | j_imi_d | j_rs_d), evaluated only in IDLE.
REQ-022 Selected target SHALL be j_target_d when j_imi_d or j_rs_d is set, else br_target_d.
REQ-023 States SHALL be IDLE and WAIT_DS; stall_d = (state == WAIT_DS).
REQ-024 fetch_req SHALL be 0 while resetn is low and 1 in every other cycle.
REQ-025 IDLE, no event: fetch_ack -> fetch_pc += 4 (32-bit wrap at 0xFFFFFFFC -> 0x00000000); no ack -> hold.
REQ-026 IDLE branch event, fetch_pc == pc_d+4 and fetch_ack = 1: the delay slot is accepted now; fetch_pc <= target; stay IDLE; no flush.
REQ-027 IDLE branch event, fetch_pc == pc_d+4 and fetch_ack = 0: latch target into pending register; go to WAIT_DS; hold fetch_pc.
REQ-028 IDLE branch event, fetch_pc != pc_d+4 (delay slot already accepted): fetch_pc <= target; stay IDLE; if fetch_ack = 1, flush_if = 1 next cycle (wrong-path fetch).
REQ-029 WAIT_DS: hold fetch_pc until fetch_ack; on ack fetch_pc <= pending target, go to IDLE; no flush.
REQ-030 Exception/ERET SHALL override all else in any state: fetch_pc <= exc_target (exc_valid) or epc (eret_valid only); state <= IDLE; pending target discarded.
REQ-031 exc_valid SHALL take priority over eret_valid when both are high.
REQ-032 Exception/ERET with fetch_ack = 1 the same cycle SHALL set flush_if = 1 next cycle.
REQ-033 Branch inputs SHALL be ignored in WAIT_DS; decode is held by stall_d.
REQ-034 flush_if SHALL be registered, high for exactly one cycle per triggering event, and otherwise 0.
REQ-035 Address arithmetic SHALL be 32-bit unsigned with carry discarded (pc_d+4 compare also wraps).

Reset
REQ-036 resetn low at a clock edge SHALL set fetch_pc = RESET_PC, state = IDLE, pending target = 0, flush_if = 0, and stall_d = 0, regardless of state (including mid-WAIT_DS).
REQ-037 Inputs SHALL be ignored in the reset cycle; fetch_req rises in the first cycle after resetn goes high.

Verification
REQ-038 Reset, then fetch_ack held high for 3 cycles -> fetch_pc 0xBFC00000, 0xBFC00004, 0xBFC00008, 0xBFC0000C; flush_if stays 0.
REQ-039 fetch_pc = 0x1004, pc_d = 0x1000, br_taken_d = 1, br_target_d = 0x2000, fetch_ack = 0 -> WAIT_DS and stall_d = 1; ack 2 cycles later -> fetch_pc = 0x2000, stall_d = 0, no flush.
REQ-040 fetch_pc = 0x1008, pc_d = 0x1000, j_rs_d = 1, j_target_d = 0x3000, fetch_ack = 1 -> next cycle fetch_pc = 0x3000 and flush_if = 1 for one cycle.
REQ-041 In WAIT_DS, exc_valid = 1, exc_target = 0xBFC00380, eret_valid = 1 -> fetch_pc = 0xBFC00380, IDLE; the pending target is never loaded.
REQ-042 resetn low while in WAIT_DS with a pending target -> fetch_pc = RESET_PC, stall_d = 0, flush_if = 0; first ack after release -> RESET_PC+4.
REQ-043 fetch_pc = 0xFFFFFFFC, fetch_ack = 1 -> fetch_pc = 0x00000000.
